game_tick_scheduler: RTL and testbench

Sequences the whack-a-mole game timebase from the single base clock: it turns the 30 MHz base into a 1 ms enable strobe and a level-dependent mole-step strobe. It owns start/pause/stop of game timing and applies difficulty-level changes through a valid/ready handshake, only at safe tick boundaries. It sits between `clock_generator`'s base clock domain and the game FSM and display logic, which consume its strobes as clock enables rather than as derived clocks.

---
 rtl/sched_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/game_tick_scheduler.sv | 111 +++++++++++
 tb/tb_game_tick_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and the clamped mole-period function for the game tick scheduler.
package sched_pkg;

    localparam int unsigned LEVEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sched_state_t;

    // The reduction is range-checked before subtracting, so the unsigned math never wraps.
    function automatic int unsigned mole_period(
        input logic [LEVEL_W-1:0] level,
        input int unsigned        max_ms,
        input int unsigned        step_ms,
        input int unsigned        min_ms
    );
        int unsigned red;
        red = 32'(level) * step_ms;
        if (red >= max_ms || (max_ms - red) < min_ms)
            return min_ms;
        return max_ms - red;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Wrapping counter with a runtime limit; tick flags the enabled cycle that completes a period.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic                       clk_base,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [$clog2(DIV+1)-1:0]   lim,
    output logic                       tick
);

    localparam int unsigned W   = $clog2(DIV + 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    // Terminal count is combinational so it can enable a cascaded counter on the same edge.
    assign tick = en && (cnt == lim - ONE);

    always_ff @(posedge clk_base) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timebase: 1 ms strobe and level-dependent mole strobe with run/pause control
// and a valid/ready level-change port applied only at mole boundaries.
module game_tick_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned BASE_FREQ    = 30_000_000,
    parameter int unsigned TICK_HZ      = 1_000,
    parameter int unsigned MOLE_MS_MAX  = 1_000,
    parameter int unsigned MOLE_MS_STEP = 100,
    parameter int unsigned MOLE_MS_MIN  = 100
) (
    input  logic               clk_base,
    input  logic               rst,
    input  logic               run,
    input  logic               pause,
    input  logic               cfg_valid,
    input  logic [LEVEL_W-1:0] cfg_level,
    output logic               cfg_ready,
    output logic               ms_tick,
    output logic               mole_tick,
    output logic [LEVEL_W-1:0] active_level,
    output logic [1:0]         state
);

    localparam int unsigned PRESCALE = BASE_FREQ / TICK_HZ;
    localparam int unsigned PW       = $clog2(PRESCALE + 1);
    localparam int unsigned MW       = $clog2(MOLE_MS_MAX + 1);

    sched_state_t        st, st_next;
    logic                pending, pending_next;
    logic [LEVEL_W-1:0]  pending_level;
    logic                accept, counting, clr;
    logic                ms_wrap, mole_wrap;
    logic [MW-1:0]       period;

    assign accept   = cfg_valid && cfg_ready;
    assign counting = run && (st == ST_RUN);
    assign clr      = !run || (st == ST_IDLE);
    assign period   = MW'(mole_period(active_level, MOLE_MS_MAX, MOLE_MS_STEP, MOLE_MS_MIN));
    assign state    = st;

    tick_prescaler #(.DIV(PRESCALE)) u_ms (
        .clk_base (clk_base),
        .rst      (rst),
        .en       (counting),
        .clr      (clr),
        .lim      (PW'(PRESCALE)),
        .tick     (ms_wrap)
    );

    tick_prescaler #(.DIV(MOLE_MS_MAX)) u_mole (
        .clk_base (clk_base),
        .rst      (rst),
        .en       (ms_wrap),
        .clr      (clr),
        .lim      (period),
        .tick     (mole_wrap)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        st_next      = st;
        pending_next = pending;
        if (!run) begin
            st_next = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE:  st_next = ST_RUN;
                ST_RUN:   if (pause)  st_next = ST_PAUSE;
                ST_PAUSE: if (!pause) st_next = ST_RUN;
                default:  st_next = ST_IDLE;
            endcase
        end

        // Stopping discards the request; a request on a mole edge waits for the next one.
        if (!run || st == ST_IDLE) begin
            pending_next = 1'b0;
        end else begin
            if (mole_wrap) pending_next = 1'b0;
            if (accept)    pending_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            st            <= ST_IDLE;
            pending       <= 1'b0;
            pending_level <= '0;
            active_level  <= '0;
            cfg_ready     <= 1'b1;
            ms_tick       <= 1'b0;
            mole_tick     <= 1'b0;
        end else begin
            st        <= st_next;
            pending   <= pending_next;
            cfg_ready <= (st_next == ST_IDLE) || !pending_next;
            ms_tick   <= ms_wrap;
            mole_tick <= mole_wrap;

            if (accept && st == ST_IDLE)
                active_level <= cfg_level;
            else if (mole_wrap && pending)
                active_level <= pending_level;

            if (accept && st != ST_IDLE)
                pending_level <= cfg_level;
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench: stimulus queues expected strobe edges, a monitor pops them as strobes appear.
module tb_game_tick_scheduler;

    localparam int P = 10;

    logic       clk_base = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_level = 3'd0;
    logic       cfg_ready, ms_tick, mole_tick;
    logic [2:0] active_level;
    logic [1:0] state;

    int cyc = 0;
    int nvec = 0;
    int nmis = 0;
    int exp_ms[$];
    int exp_mole[$];
    int ms_e, mole_e;

    game_tick_scheduler #(
        .BASE_FREQ    (10_000),
        .TICK_HZ      (1_000),
        .MOLE_MS_MAX  (10),
        .MOLE_MS_STEP (1),
        .MOLE_MS_MIN  (4)
    ) dut (
        .clk_base     (clk_base),
        .rst          (rst),
        .run          (run),
        .pause        (pause),
        .cfg_valid    (cfg_valid),
        .cfg_level    (cfg_level),
        .cfg_ready    (cfg_ready),
        .ms_tick      (ms_tick),
        .mole_tick    (mole_tick),
        .active_level (active_level),
        .state        (state)
    );

    always #5 clk_base = ~clk_base;

    // After posedge number e, cyc reads e at the following negedge.
    always @(posedge clk_base) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe seen must match the head of its expectation queue.
    always @(negedge clk_base) begin
        if (ms_tick === 1'b1) begin
            if (exp_ms.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL ms_tick unexpected: got pulse at edge %0d, expected none", cyc);
            end else begin
                ms_e = exp_ms.pop_front();
                check("ms_tick edge", cyc, ms_e);
            end
        end
        if (mole_tick === 1'b1) begin
            if (exp_mole.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL mole_tick unexpected: got pulse at edge %0d, expected none", cyc);
            end else begin
                mole_e = exp_mole.pop_front();
                check("mole_tick edge", cyc, mole_e);
            end
        end
    end

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk_base);
    endtask

    task automatic start_run(output int k);
        run = 1'b1;
        k   = cyc + 1;
    endtask

    task automatic push_ms(input int k, input int stop);
        for (int t = k + P; t < stop; t += P) exp_ms.push_back(t);
    endtask

    task automatic stop_at(input int s);
        wait_edge(s - 1);
        run = 1'b0;
        @(negedge clk_base);
        check("state idle after stop", int'(state), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " state"},        int'(state), 0);
        check({tag, " ms_tick"},      int'(ms_tick), 0);
        check({tag, " mole_tick"},    int'(mole_tick), 0);
        check({tag, " active_level"}, int'(active_level), 0);
        check({tag, " cfg_ready"},    int'(cfg_ready), 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;

        // Scenario 1: reset for 3 cycles, then free run at level 0 (period 100 cycles).
        repeat (3) @(negedge clk_base);
        check_reset("reset");
        rst = 1'b0;
        start_run(k);
        push_ms(k, k + 206);
        exp_mole.push_back(k + 100);
        exp_mole.push_back(k + 200);
        @(negedge clk_base);
        check("s1 state run", int'(state), 1);
        stop_at(k + 206);

        // Scenario 2: 37-cycle pause starting at pc=4 shifts later strobes by 37.
        @(negedge clk_base);
        start_run(k);
        exp_ms.push_back(k + 10);
        exp_ms.push_back(k + 20);
        for (int t = k + 67; t < k + 141; t += P) exp_ms.push_back(t);
        exp_mole.push_back(k + 137);
        wait_edge(k + 24);
        pause = 1'b1;
        @(negedge clk_base);
        check("s2 state pause", int'(state), 2);
        wait_edge(k + 61);
        check("s2 still paused", int'(state), 2);
        pause = 1'b0;
        @(negedge clk_base);
        check("s2 resumed", int'(state), 1);
        stop_at(k + 141);

        // Scenario 3: level 3 requested mid-interval, then level 5 on a mole edge.
        @(negedge clk_base);
        start_run(k);
        push_ms(k, k + 395);
        exp_mole.push_back(k + 100);
        exp_mole.push_back(k + 200);
        exp_mole.push_back(k + 270);
        exp_mole.push_back(k + 340);
        exp_mole.push_back(k + 390);
        wait_edge(k + 114);
        check("s3 ready before req", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_level = 3'd3;
        @(negedge clk_base);
        cfg_valid = 1'b0;
        check("s3 ready after accept", int'(cfg_ready), 0);
        check("s3 level held", int'(active_level), 0);
        wait_edge(k + 199);
        check("s3 level before mole", int'(active_level), 0);
        check("s3 ready before mole", int'(cfg_ready), 0);
        @(negedge clk_base);
        check("s3 level applied", int'(active_level), 3);
        check("s3 ready restored", int'(cfg_ready), 1);
        wait_edge(k + 269);
        cfg_valid = 1'b1;
        cfg_level = 3'd5;
        @(negedge clk_base);
        cfg_valid = 1'b0;
        check("s3 same-edge req not applied", int'(active_level), 3);
        check("s3 ready low on mole-edge req", int'(cfg_ready), 0);
        wait_edge(k + 340);
        check("s3 level 5 applied", int'(active_level), 5);
        check("s3 ready after 2nd apply", int'(cfg_ready), 1);
        stop_at(k + 395);
        check("s3 level retained in idle", int'(active_level), 5);

        // Scenario 4: level 7 loaded in IDLE, period clamps to 4 ms.
        @(negedge clk_base);
        cfg_valid = 1'b1;
        cfg_level = 3'd7;
        @(negedge clk_base);
        cfg_valid = 1'b0;
        check("s4 level immediate", int'(active_level), 7);
        check("s4 ready idle", int'(cfg_ready), 1);
        start_run(k);
        push_ms(k, k + 125);
        exp_mole.push_back(k + 40);
        exp_mole.push_back(k + 80);
        exp_mole.push_back(k + 120);
        stop_at(k + 125);

        // Scenario 5: stop with pause high and a level pending, then restart.
        @(negedge clk_base);
        start_run(k);
        push_ms(k, k + 20);
        wait_edge(k + 14);
        cfg_valid = 1'b1;
        cfg_level = 3'd2;
        @(negedge clk_base);
        cfg_valid = 1'b0;
        check("s5 pending ready low", int'(cfg_ready), 0);
        wait_edge(k + 19);
        run   = 1'b0;
        pause = 1'b1;
        @(negedge clk_base);
        check("s5 state idle", int'(state), 0);
        check("s5 ready after stop", int'(cfg_ready), 1);
        check("s5 level kept", int'(active_level), 7);
        pause = 1'b0;
        start_run(k2);
        push_ms(k2, k2 + 85);
        exp_mole.push_back(k2 + 40);
        exp_mole.push_back(k2 + 80);
        wait_edge(k2 + 80);
        check("s5 pending discarded", int'(active_level), 7);
        stop_at(k2 + 85);

        // Scenario 6: reset mid-run at pc=7; restart begins cleanly after it.
        @(negedge clk_base);
        start_run(k);
        wait_edge(k + 7);
        rst = 1'b1;
        @(negedge clk_base);
        check_reset("s6 mid-run reset");
        rst = 1'b0;
        push_ms(k + 9, k + 25);
        stop_at(k + 25);

        repeat (5) @(negedge clk_base);
        check("ms queue drained", exp_ms.size(), 0);
        check("mole queue drained", exp_mole.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
